// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: default widths, state/trigger/field encodings and entry layout for wb_trace.
// The WB_TRACE_TS_EN build adds a timestamp field to each trace entry.
`ifndef WB_TRACE_DATA_W
`define WB_TRACE_DATA_W 16
`endif
`ifndef WB_TRACE_PC_W
`define WB_TRACE_PC_W 16
`endif
`ifndef WB_TRACE_REG_AW
`define WB_TRACE_REG_AW 4
`endif
`ifndef WB_TRACE_DEPTH
`define WB_TRACE_DEPTH 16
`endif
`ifndef WB_TRACE_TS_W
`define WB_TRACE_TS_W 16
`endif

package wb_trace_pkg;

    localparam int WB_DATA_W = `WB_TRACE_DATA_W;
    localparam int WB_PC_W   = `WB_TRACE_PC_W;
    localparam int WB_REG_AW = `WB_TRACE_REG_AW;
    localparam int WB_DEPTH  = `WB_TRACE_DEPTH;
    localparam int WB_TS_W   = `WB_TRACE_TS_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam logic [1:0] TRIG_NEVER     = 2'd0;
    localparam logic [1:0] TRIG_ADDR      = 2'd1;
    localparam logic [1:0] TRIG_ADDR_DATA = 2'd2;
    localparam logic [1:0] TRIG_IMM       = 2'd3;

    localparam logic [1:0] FIELD_WDATA = 2'd0;
    localparam logic [1:0] FIELD_WADDR = 2'd1;
    localparam logic [1:0] FIELD_PC    = 2'd2;
    localparam logic [1:0] FIELD_TS    = 2'd3;

    typedef struct packed {
`ifdef WB_TRACE_TS_EN
        logic [WB_TS_W-1:0]   ts;
`endif
        logic [WB_PC_W-1:0]   pc;
        logic [WB_REG_AW-1:0] waddr;
        logic [WB_DATA_W-1:0] wdata;
    } trace_entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x WIDTH storage, one write port and one registered read port.
// A read of the slot being written in the same cycle returns the previous contents.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // storage array write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // registered read; samples the array before this edge's write lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/wb_trace.sv
// wb_trace: triggered circular trace of regfile writebacks with post-trigger capture.
// Define WB_TRACE_TS_EN to store and read back a per-entry timestamp.
module wb_trace
    import wb_trace_pkg::*;
#(
    parameter  int DATA_W = WB_DATA_W,
    parameter  int PC_W   = WB_PC_W,
    parameter  int REG_AW = WB_REG_AW,
    parameter  int DEPTH  = WB_DEPTH,
    parameter  int TS_W   = WB_TS_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int RD_W   = max3(DATA_W, PC_W, TS_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_waddr_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              arm_i,
    input  logic [1:0]        trig_mode_i,
    input  logic [REG_AW-1:0] trig_addr_i,
    input  logic [DATA_W-1:0] trig_data_i,
    input  logic [AW-1:0]     post_cnt_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_idx_i,
    input  logic [1:0]        rd_field_i,
    output logic [RD_W-1:0]   rd_data_o,
    output logic              rd_valid_o,
    output logic [1:0]        state_o,
    output logic [AW:0]       count_o,
    output logic [AW-1:0]     trig_idx_o
);

`ifdef WB_TRACE_TS_EN
    localparam int EW = TS_W + PC_W + REG_AW + DATA_W;
`else
    localparam int EW = PC_W + REG_AW + DATA_W;
`endif
    localparam int CW = AW + 1;

    trace_state_e    state_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   remaining_r;
    logic [AW-1:0]   trig_idx_r;
    logic            rd_valid_r;
    logic            rd_oor_r;
    logic [1:0]      rd_field_r;

    logic [AW-1:0]   oldest_s;
    logic [AW-1:0]   rd_addr_s;
    logic            full_s;
    logic            rd_oor_s;
    logic            rec_s;
    logic            hit_s;
    logic [EW-1:0]   wr_entry_s;
    logic [EW-1:0]   ram_q_s;
    logic [RD_W-1:0] rd_data_s;

    // when full the low count bits are zero, so oldest coincides with the write pointer
    assign oldest_s  = wr_ptr_r - count_r[AW-1:0];
    assign full_s    = count_r[AW];
    assign rd_addr_s = oldest_s + rd_idx_i;
    assign rd_oor_s  = ({1'b0, rd_idx_i} >= count_r);

`ifdef WB_TRACE_TS_EN
    logic [TS_W-1:0] ts_r;

    // free-running capture timestamp
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_r <= '0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    assign wr_entry_s = {ts_r, pc_i, wb_waddr_i, wb_wdata_i};
`else
    assign wr_entry_s = {pc_i, wb_waddr_i, wb_wdata_i};
`endif

    // a write is captured only while recording and never in an arm cycle
    always_comb begin
        rec_s = 1'b0;
        if (arm_i) begin
            rec_s = 1'b0;
        end else if ((state_r == ST_ARMED) || (state_r == ST_POST)) begin
            rec_s = wb_we_i;
        end else begin
            rec_s = 1'b0;
        end
    end

    // trigger condition for the current writeback
    always_comb begin
        hit_s = 1'b0;
        case (trig_mode_i)
            TRIG_NEVER:     hit_s = 1'b0;
            TRIG_ADDR:      hit_s = (wb_waddr_i == trig_addr_i);
            TRIG_ADDR_DATA: hit_s = (wb_waddr_i == trig_addr_i) && (wb_wdata_i == trig_data_i);
            TRIG_IMM:       hit_s = 1'b1;
            default:        hit_s = 1'b0;
        endcase
    end

    // capture FSM, buffer pointers and trigger index tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            remaining_r <= '0;
            trig_idx_r  <= '0;
        end else if (arm_i) begin
            state_r     <= ST_ARMED;
            wr_ptr_r    <= '0;
            count_r     <= '0;
            remaining_r <= '0;
            trig_idx_r  <= '0;
        end else if (rec_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
            if (!full_s) begin
                count_r <= count_r + CW'(1);
            end
            case (state_r)
                ST_ARMED: begin
                    if (hit_s) begin
                        trig_idx_r <= full_s ? AW'(DEPTH - 1) : count_r[AW-1:0];
                        if (post_cnt_i == '0) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r     <= ST_POST;
                            remaining_r <= post_cnt_i;
                        end
                    end
                end
                ST_POST: begin
                    remaining_r <= remaining_r - AW'(1);
                    if (remaining_r == AW'(1)) begin
                        state_r <= ST_DONE;
                    end
                    // overwriting the oldest slot shifts every relative index down by one
                    if (full_s && (trig_idx_r != '0)) begin
                        trig_idx_r <= trig_idx_r - AW'(1);
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

    // read pipeline: validity, range flag and field select aligned with the RAM output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_r <= 1'b0;
            rd_oor_r   <= 1'b0;
            rd_field_r <= FIELD_WDATA;
        end else begin
            rd_valid_r <= rd_en_i;
            if (rd_en_i) begin
                rd_oor_r   <= rd_oor_s;
                rd_field_r <= rd_field_i;
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_trace_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (rec_s),
        .waddr (wr_ptr_r),
        .wdata (wr_entry_s),
        .re    (rd_en_i),
        .raddr (rd_addr_s),
        .rdata (ram_q_s)
    );

    // field select on the registered RAM word
    always_comb begin
        rd_data_s = '0;
        if (rd_oor_r) begin
            rd_data_s = '0;
        end else begin
            case (rd_field_r)
                FIELD_WDATA: rd_data_s = RD_W'(ram_q_s[DATA_W-1:0]);
                FIELD_WADDR: rd_data_s = RD_W'(ram_q_s[DATA_W +: REG_AW]);
                FIELD_PC:    rd_data_s = RD_W'(ram_q_s[DATA_W + REG_AW +: PC_W]);
`ifdef WB_TRACE_TS_EN
                FIELD_TS:    rd_data_s = RD_W'(ram_q_s[DATA_W + REG_AW + PC_W +: TS_W]);
`else
                FIELD_TS:    rd_data_s = '0;
`endif
                default:     rd_data_s = '0;
            endcase
        end
    end

    assign rd_data_o  = rd_data_s;
    assign rd_valid_o = rd_valid_r;
    assign state_o    = state_r;
    assign count_o    = count_r;
    assign trig_idx_o = trig_idx_r;

endmodule
